// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer_if
// Description : Request, shifter and result signals of shift_sequencer.
//               master = client/shifter side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [0:WIDTH-1]   req_data0;
    logic [0:WIDTH-1]   req_data1;
    logic [CNT_W-1:0]   req_cnt0;
    logic [CNT_W-1:0]   req_cnt1;
    logic [0:WIDTH-1]   sh_ip;
    logic [0:WIDTH-1]   sh_op;
    logic               res_valid;
    logic               res_ready;
    logic [0:WIDTH-1]   res_data;
    logic               res_id;
    logic               busy;

    modport master (
        output req_valid, req_data0, req_data1, req_cnt0, req_cnt1,
        output sh_op, res_ready,
        input  req_ready, sh_ip, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_data0, req_data1, req_cnt0, req_cnt1,
        input  sh_op, res_ready,
        output req_ready, sh_ip, res_valid, res_data, res_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Shares one external combinational shifter between two
//               requesters. Round-robin accepts a word and a pass count,
//               feeds the word through the shifter once per clock for that
//               many passes, then holds the result under valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    shift_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [0:WIDTH-1]   r_work;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_id;
    logic               r_last_grant;

    logic               w_grant_vld;
    logic               w_grant_id;
    logic [0:WIDTH-1]   w_sel_data;
    logic [CNT_W-1:0]   w_sel_cnt;

    // Round-robin arbitration, only meaningful while idle
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (r_state == ST_IDLE) begin
            case (bus.req_valid)
                2'b01:   begin w_grant_vld = 1'b1; w_grant_id = 1'b0;          end
                2'b10:   begin w_grant_vld = 1'b1; w_grant_id = 1'b1;          end
                2'b11:   begin w_grant_vld = 1'b1; w_grant_id = ~r_last_grant; end
                default: begin w_grant_vld = 1'b0; w_grant_id = 1'b0;          end
            endcase
        end
    end

    assign w_sel_data = w_grant_id ? bus.req_data1 : bus.req_data0;
    assign w_sel_cnt  = w_grant_id ? bus.req_cnt1  : bus.req_cnt0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a zero count skips RUN and goes straight to DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_state_next = (w_sel_cnt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Work register, pass counter and grant bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work       <= '0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_work       <= w_sel_data;
                        r_cnt        <= w_sel_cnt;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                    end
                end
                ST_RUN: begin
                    // RUN is only entered with a non-zero count, so no underflow
                    r_work <= bus.sh_op;
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_grant_vld ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.sh_ip     = r_work;
    assign bus.res_data  = r_work;
    assign bus.res_valid = (r_state == ST_DONE);
    assign bus.res_id    = r_id;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer with a rotate-left
//               shifter model and a round-robin / rotation reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   m_last;

    shift_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shifter: rotate one position toward index 0 (the MSB)
    assign bus.sh_op = {bus.sh_ip[1:7], bus.sh_ip[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rotl(input logic [7:0] d, input int n);
        int s;
        s = n % 8;
        return (d << s) | (d >> ((8 - s) % 8));
    endfunction

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return 1 - m_last;
        else if (v == 2'b10) return 1;
        else return 0;
    endfunction

    // Drives one request, returns what was observed (no checking here)
    task automatic run_req(input logic [1:0] v, input logic [7:0] d0, input logic [3:0] c0,
                           input logic [7:0] d1, input logic [3:0] c1,
                           output logic [1:0] gready, output int lat, output logic [7:0] rdata,
                           output int rid, output bit busy_bad, output bit tmo);
        int k;
        tmo = 0; busy_bad = 0; gready = 2'b00; lat = -1; rdata = '0; rid = -1;
        @(negedge clk);
        bus.req_valid = v; bus.req_data0 = d0; bus.req_cnt0 = c0;
        bus.req_data1 = d1; bus.req_cnt1 = c1; bus.res_ready = 1'b1;
        #1;
        k = 0;
        while (bus.req_ready == 2'b00 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (bus.req_ready == 2'b00) begin
            tmo = 1; bus.req_valid = 2'b00; return;
        end
        gready = bus.req_ready;
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        k = 0;
        while (!bus.res_valid && k < 40) begin
            if (!bus.busy) busy_bad = 1;
            @(negedge clk); #1; k++;
        end
        if (!bus.res_valid) begin
            tmo = 1; return;
        end
        if (!bus.busy) busy_bad = 1;
        lat = k; rdata = bus.res_data; rid = bus.res_id;
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.res_ready = 1'b1;
        while (bus.busy && k < 40) begin
            @(negedge clk); #1; k++;
        end
        checks++;
        if (bus.busy) begin
            errors++; $display("FAIL drain: busy still %b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 2'b00; bus.req_data0 = '0; bus.req_data1 = '0;
        bus.req_cnt0 = '0; bus.req_cnt1 = '0; bus.res_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
        checks++; if (bus.res_valid !== 1'b0)  begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        checks++; if (bus.res_data !== 8'h00)  begin errors++; $display("FAIL reset_res_data: got %h expected 00", bus.res_data); end
        checks++; if (bus.sh_ip !== 8'h00)     begin errors++; $display("FAIL reset_sh_ip: got %h expected 00", bus.sh_ip); end
        checks++; if (bus.res_id !== 1'b0)     begin errors++; $display("FAIL reset_res_id: got %b expected 0", bus.res_id); end
        checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst = 1'b0;
        m_last = 1;
    endtask

    task automatic test_single();
        logic [1:0] g; int lat; logic [7:0] d; int id; bit bb; bit tmo;
        run_req(2'b01, 8'b0000_0001, 4'd3, 8'h00, 4'd0, g, lat, d, id, bb, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL single_timeout: got timeout expected result"); end
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", g); end
        checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", lat); end
        checks++; if (d !== 8'b0000_1000) begin errors++; $display("FAIL single_data: got %b expected 00001000", d); end
        checks++; if (id != 0) begin errors++; $display("FAIL single_id: got %0d expected 0", id); end
        checks++; if (bb) begin errors++; $display("FAIL single_busy: got busy low during op expected high"); end
        m_last = 0;
        @(negedge clk); #1;
        checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL single_after: got busy %b res_valid %b expected 0 0", bus.busy, bus.res_valid);
        end
    endtask

    task automatic test_zero();
        logic [1:0] g; int lat; logic [7:0] d; int id; bit bb; bit tmo;
        run_req(2'b10, 8'h00, 4'd0, 8'hA5, 4'd0, g, lat, d, id, bb, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL zero_timeout: got timeout expected result"); end
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL zero_grant: got %b expected 10", g); end
        checks++; if (lat != 0) begin errors++; $display("FAIL zero_latency: got %0d expected 0", lat); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL zero_data: got %h expected a5", d); end
        checks++; if (id != 1) begin errors++; $display("FAIL zero_id: got %0d expected 1", id); end
        m_last = 1;
    endtask

    task automatic test_round_robin();
        int acc_cyc[$]; int acc_id[$]; int res_id_q[$]; logic [7:0] res_d_q[$];
        logic [7:0] dd [2];
        int exp_id;
        dd[0] = 8'h01; dd[1] = 8'h80;
        @(negedge clk);
        bus.req_valid = 2'b11; bus.req_data0 = dd[0]; bus.req_cnt0 = 4'd1;
        bus.req_data1 = dd[1]; bus.req_cnt1 = 4'd1; bus.res_ready = 1'b1;
        #1;
        for (int c = 0; c < 14; c++) begin
            if (bus.req_ready != 2'b00) begin
                acc_cyc.push_back(c);
                acc_id.push_back(bus.req_ready == 2'b10 ? 1 : 0);
            end
            if (bus.res_valid) begin
                res_id_q.push_back(int'(bus.res_id));
                res_d_q.push_back(bus.res_data);
            end
            @(negedge clk); #1;
        end
        bus.req_valid = 2'b00;
        checks++; if (acc_id.size() < 4 || res_id_q.size() < 4) begin
            errors++; $display("FAIL rr_count: got %0d accepts %0d results expected at least 4 each", acc_id.size(), res_id_q.size());
        end
        for (int i = 0; i < acc_id.size(); i++) begin
            exp_id = pick(2'b11);
            checks++; if (acc_id[i] != exp_id) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, acc_id[i], exp_id); end
            m_last = exp_id;
            if (i > 0) begin
                checks++; if (acc_cyc[i] - acc_cyc[i-1] != 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected 3", i, acc_cyc[i] - acc_cyc[i-1]); end
            end
        end
        for (int i = 0; i < res_id_q.size() && i < acc_id.size(); i++) begin
            checks++; if (res_id_q[i] != acc_id[i] || res_d_q[i] !== rotl(dd[acc_id[i]], 1)) begin
                errors++; $display("FAIL rr_result%0d: got id %0d data %h expected id %0d data %h", i, res_id_q[i], res_d_q[i], acc_id[i], rotl(dd[acc_id[i]], 1));
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] hd; logic hid; int k; logic [7:0] din;
        din = 8'($urandom);
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.req_valid = 2'b01; bus.req_data0 = din; bus.req_cnt0 = 4'd2;
        bus.req_data1 = 8'h3C; bus.req_cnt1 = 4'd0;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant: got %b expected 01", bus.req_ready); end
        m_last = 0;
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        k = 0;
        while (!bus.res_valid && k < 20) begin @(negedge clk); #1; k++; end
        checks++; if (!bus.res_valid) begin errors++; $display("FAIL bp_timeout: got res_valid 0 expected 1"); end
        hd = bus.res_data; hid = bus.res_id;
        checks++; if (hd !== rotl(din, 2) || hid !== 1'b0) begin
            errors++; $display("FAIL bp_result: got data %h id %b expected data %h id 0", hd, hid, rotl(din, 2));
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== hd || bus.res_id !== hid || bus.req_ready !== 2'b00) begin
                errors++; $display("FAIL bp_hold%0d: got valid %b data %h id %b req_ready %b expected 1 %h %b 00",
                                   c, bus.res_valid, bus.res_data, bus.res_id, bus.req_ready, hd, hid);
            end
        end
        bus.res_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.req_ready !== (pick(2'b11) == 1 ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL bp_next_grant: got %b expected %b", bus.req_ready, (pick(2'b11) == 1 ? 2'b10 : 2'b01));
        end
        m_last = pick(2'b11);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        drain();
    endtask

    task automatic test_max();
        logic [1:0] g; int lat; logic [7:0] d; int id; bit bb; bit tmo;
        run_req(2'b01, 8'b1000_0000, 4'd15, 8'h00, 4'd0, g, lat, d, id, bb, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL max_timeout: got timeout expected result"); end
        checks++; if (lat != 15) begin errors++; $display("FAIL max_latency: got %0d expected 15", lat); end
        checks++; if (d !== 8'b0100_0000) begin errors++; $display("FAIL max_data: got %b expected 01000000", d); end
        m_last = 0;
    endtask

    task automatic test_random();
        logic [1:0] g; int lat; logic [7:0] d; int id; bit bb; bit tmo;
        logic [1:0] v; logic [7:0] d0, d1; logic [3:0] c0, c1;
        int eid; int ecnt; logic [7:0] edata;
        for (int i = 0; i < 16; i++) begin
            v  = 2'($urandom_range(1, 3));
            d0 = 8'($urandom); d1 = 8'($urandom);
            c0 = 4'($urandom_range(0, 15)); c1 = 4'($urandom_range(0, 15));
            eid   = pick(v);
            ecnt  = (eid == 1) ? int'(c1) : int'(c0);
            edata = rotl((eid == 1) ? d1 : d0, ecnt);
            run_req(v, d0, c0, d1, c1, g, lat, d, id, bb, tmo);
            checks++; if (tmo || g !== (eid == 1 ? 2'b10 : 2'b01) || id != eid || lat != ecnt || d !== edata) begin
                errors++; $display("FAIL rand%0d: got tmo %0b grant %b id %0d lat %0d data %h expected grant %b id %0d lat %0d data %h",
                                   i, tmo, g, id, lat, d, (eid == 1 ? 2'b10 : 2'b01), eid, ecnt, edata);
            end
            m_last = eid;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [1:0] g; int lat; logic [7:0] d; int id; bit bb; bit tmo;
        bit seen;
        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.req_valid = 2'b01; bus.req_data0 = 8'b1111_0000; bus.req_cnt0 = 4'd8;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b expected 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b00 || bus.res_valid !== 1'b0 || bus.res_data !== 8'h00 ||
                      bus.sh_ip !== 8'h00 || bus.res_id !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got ready %b valid %b data %h ip %h id %b busy %b expected all 0",
                               bus.req_ready, bus.res_valid, bus.res_data, bus.sh_ip, bus.res_id, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last = 1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (bus.res_valid || bus.busy) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_no_result: got activity after reset expected none"); end
        run_req(2'b11, 8'h12, 4'd1, 8'h34, 4'd1, g, lat, d, id, bb, tmo);
        checks++; if (tmo || g !== 2'b01 || d !== rotl(8'h12, 1)) begin
            errors++; $display("FAIL mid_post_grant: got tmo %0b grant %b data %h expected grant 01 data %h", tmo, g, d, rotl(8'h12, 1));
        end
        m_last = 0;
        @(negedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_last = 1;
        test_reset();
        test_single();
        test_zero();
        test_round_robin();
        test_backpressure();
        test_max();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
